// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, fixed latency.
// Optional build macro SEQ_DIVIDER_SIGNED_EN adds two's complement support
// (divide magnitudes, then sign-correct). Without it signed_op is accepted
// but ignored and every division is unsigned.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] quo_reg, quo_next;
    logic [WIDTH-1:0] rem_reg, rem_next;
    logic [WIDTH-1:0] dsr_reg, dsr_next;
    logic             dz_reg, dz_next;

    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dsr_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             trial_ok;
    logic             accept;

    assign accept = (state_reg == IDLE) && start;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic dvd_neg;
    logic dsr_neg;
    logic neg_q_reg;
    logic neg_r_reg;

    assign dvd_neg = signed_op & dividend[WIDTH-1];
    assign dsr_neg = signed_op & divisor[WIDTH-1];
    // The most-negative value maps onto itself, which is the correct
    // unsigned magnitude 2^(WIDTH-1).
    assign dvd_mag = dvd_neg ? (~dividend + 1'b1) : dividend;
    assign dsr_mag = dsr_neg ? (~divisor + 1'b1) : divisor;

    // Remember the result signs at accept; a zero divisor reports raw bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
        end else if (accept) begin
            neg_q_reg <= (divisor != '0) & (dvd_neg ^ dsr_neg);
            neg_r_reg <= (divisor != '0) & dvd_neg;
        end
    end

    assign quotient  = neg_q_reg ? (~quo_reg + 1'b1) : quo_reg;
    assign remainder = neg_r_reg ? (~rem_reg + 1'b1) : rem_reg;
`else
    logic sign_unused;

    assign sign_unused = signed_op;
    assign dvd_mag     = dividend;
    assign dsr_mag     = divisor;
    assign quotient    = quo_reg;
    assign remainder   = rem_reg;
`endif

    // Trial subtract of the shifted partial remainder. Because the partial
    // remainder is always below the divisor, shifted < 2*divisor, so a
    // WIDTH+1-bit difference is negative exactly when its top bit is set.
    always_comb begin
        shifted  = {rem_reg, quo_reg[WIDTH-1]};
        diff     = shifted - {1'b0, dsr_reg};
        trial_ok = ~diff[WIDTH];
    end

    // Next-state logic: accept in IDLE, one bit per RUN cycle, report in FINISH.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        quo_next   = quo_reg;
        rem_next   = rem_reg;
        dsr_next   = dsr_reg;
        dz_next    = dz_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    dsr_next = dsr_mag;
                    if (divisor == '0) begin
                        // Zero divisor: no iterations; the counter holds the
                        // result back one cycle so done lands in cycle 2.
                        dz_next    = 1'b1;
                        quo_next   = '1;
                        rem_next   = dividend;
                        count_next = CW'(1);
                        state_next = FINISH;
                    end else begin
                        dz_next    = 1'b0;
                        quo_next   = dvd_mag;
                        rem_next   = '0;
                        count_next = CW'(WIDTH - 1);
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                // quo_reg doubles as the dividend shift register: dividend
                // bits leave at the top while quotient bits enter at the bottom.
                quo_next = {quo_reg[WIDTH-2:0], trial_ok};
                rem_next = trial_ok ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                if (count_reg == '0) begin
                    state_next = FINISH;
                end else begin
                    count_next = count_reg - 1'b1;
                end
            end
            FINISH: begin
                if (count_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    count_next = count_reg - 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    // State and datapath registers; reset clears every visible result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            count_reg <= '0;
            quo_reg   <= '0;
            rem_reg   <= '0;
            dsr_reg   <= '0;
            dz_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            quo_reg   <= quo_next;
            rem_reg   <= rem_next;
            dsr_reg   <= dsr_next;
            dz_reg    <= dz_next;
        end
    end

    assign done        = (state_reg == FINISH) && (count_reg == '0);
    assign busy        = (state_reg == RUN) || ((state_reg == FINISH) && (count_reg != '0));
    assign div_by_zero = dz_reg & ~busy;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table plus hand-written
// sequences for ignored start, mid-division reset and back-to-back starts.
module tb_seq_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start;
    logic         signed_op;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_op   (signed_op),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sgn;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           lat;
    } vec_t;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           lat;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                                input logic [W-1:0] q, input logic [W-1:0] r, input logic dz,
                                input int lat);
        vec_t v;
        v.a = a; v.b = b; v.sgn = sgn; v.q = q; v.r = r; v.dz = dz; v.lat = lat;
        return v;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Drive operands with start high and record the expected result.
    task automatic launch(input vec_t v);
        exp_t e;
        dividend  = v.a;
        divisor   = v.b;
        signed_op = v.sgn;
        start     = 1'b1;
        e.q = v.q; e.r = v.r; e.dz = v.dz; e.lat = v.lat;
        sb.push_back(e);
    endtask

    // Called at the negedge where done was expected; pops the scoreboard.
    task automatic check_done(input int n, input string tag);
        exp_t e;
        if (!done) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s_timeout: no done after %0d cycles, expected done", tag, n);
            if (sb.size() != 0) void'(sb.pop_front());
        end else if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s_unexpected: done seen at cycle %0d, expected none", tag, n);
        end else begin
            e = sb.pop_front();
            check({tag, "_lat"}, W'(n), W'(e.lat));
            check({tag, "_quo"}, quotient, e.q);
            check({tag, "_rem"}, remainder, e.r);
            check({tag, "_dz"}, W'(div_by_zero), W'(e.dz));
        end
    endtask

    // Complete a launched division: drop start, wait for done, check the
    // single-cycle pulse and that the result holds afterwards.
    task automatic finish_vec(input vec_t v, input string tag);
        int n;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_done(n, tag);
        @(negedge clk);
        check({tag, "_pulse"}, W'(done), W'(0));
        check({tag, "_idle"}, W'(busy), W'(0));
        check({tag, "_hold"}, quotient, v.q);
    endtask

    initial begin
        vec_t v;
        int   n;
        int   cnt;

        // Unsigned reference vectors (valid in either build).
        vecs.push_back(mk(32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0, 33));
        vecs.push_back(mk(32'h12345678,   32'd0,          1'b0, 32'hFFFFFFFF,   32'h12345678,   1'b1, 2));
        vecs.push_back(mk(32'd5,          32'd9,          1'b0, 32'd0,          32'd5,          1'b0, 33));
        vecs.push_back(mk(32'hFFFFFFFF,   32'd1,          1'b0, 32'hFFFFFFFF,   32'd0,          1'b0, 33));
        vecs.push_back(mk(32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 32'd1,          32'd0,          1'b0, 33));
        vecs.push_back(mk(32'h80000000,   32'd3,          1'b0, 32'h2AAAAAAA,   32'd2,          1'b0, 33));
        vecs.push_back(mk(32'd0,          32'd5,          1'b0, 32'd0,          32'd0,          1'b0, 33));
        vecs.push_back(mk(32'd1000000,    32'd1000,       1'b0, 32'd1000,       32'd0,          1'b0, 33));
        vecs.push_back(mk(32'd0,          32'd0,          1'b0, 32'hFFFFFFFF,   32'd0,          1'b1, 2));
        vecs.push_back(mk(32'hFFFFFFF9,   32'd2,          1'b0, 32'h7FFFFFFC,   32'd1,          1'b0, 33));
`ifdef SEQ_DIVIDER_SIGNED_EN
        vecs.push_back(mk(32'hFFFFFFF9,   32'd2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 33));
        vecs.push_back(mk(32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0,          1'b0, 33));
        vecs.push_back(mk(32'd7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,   32'd1,          1'b0, 33));
        vecs.push_back(mk(32'hFFFFFFF9,   32'hFFFFFFFE,   1'b1, 32'd3,          32'hFFFFFFFF,   1'b0, 33));
        vecs.push_back(mk(32'hFFFFFFF9,   32'd0,          1'b1, 32'hFFFFFFFF,   32'hFFFFFFF9,   1'b1, 2));
`else
        vecs.push_back(mk(32'hFFFFFFF9,   32'd2,          1'b1, 32'h7FFFFFFC,   32'd1,          1'b0, 33));
        vecs.push_back(mk(32'h80000000,   32'hFFFFFFFF,   1'b1, 32'd0,          32'h80000000,   1'b0, 33));
`endif

        start     = 1'b0;
        signed_op = 1'b0;
        dividend  = '0;
        divisor   = '0;

        // Reset state.
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_quo", quotient, '0);
        check("rst_rem", remainder, '0);
        check("rst_dz", W'(div_by_zero), W'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            launch(vecs[i]);
            finish_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Second start during busy is ignored, operand changes have no effect.
        v = mk(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 33);
        launch(v);
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
            if (n == 10) begin
                check("ign_busy_c10", W'(busy), W'(1));
                dividend = 32'd9;
                divisor  = 32'd3;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        check_done(n, "ign");
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check("ign_extra_done", W'(cnt), W'(0));
        check("ign_hold_quo", quotient, 32'd14);
        check("ign_hold_rem", remainder, 32'd2);

        // Reset mid-division aborts it; first start after release is taken.
        v = mk(32'd1000, 32'd7, 1'b0, 32'd142, 32'd6, 1'b0, 33);
        launch(v);
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (n < 15) begin
            @(negedge clk);
            n++;
        end
        rst_n = 1'b0;
        #1;
        check("abort_busy", W'(busy), W'(0));
        check("abort_done", W'(done), W'(0));
        check("abort_quo", quotient, '0);
        check("abort_rem", remainder, '0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        v = mk(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 33);
        launch(v);
        finish_vec(v, "after_rst");

        // Start held high: the next division begins in the IDLE cycle after done.
        v = mk(32'd20, 32'd3, 1'b0, 32'd6, 32'd2, 1'b0, 33);
        launch(v);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 100);
        check_done(n, "b2b_first");
        v = mk(32'd50, 32'd7, 1'b0, 32'd7, 32'd1, 1'b0, 34);
        launch(v);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 100);
        check_done(n, "b2b_second");
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("b2b_idle", W'(busy), W'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
